gate_reduce_seq: RTL



---
 rtl/gate_reduce_pkg.sv | 47 ++++
 rtl/gate_reduce_alu.sv | 22 ++
 rtl/gate_reduce_seq.sv | 116 +++++++++++
 3 files changed

// File: rtl/gate_reduce_pkg.sv
// Shared encodings and helpers for the sequential gate reduction block:
// mode codes, FSM states, base-op selection, identity and inversion decode.
package gate_reduce_pkg;

    localparam logic [2:0] MODE_AND  = 3'b000;
    localparam logic [2:0] MODE_OR   = 3'b001;
    localparam logic [2:0] MODE_XOR  = 3'b010;
    localparam logic [2:0] MODE_NAND = 3'b011;
    localparam logic [2:0] MODE_NOR  = 3'b100;
    localparam logic [2:0] MODE_XNOR = 3'b101;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;

    // Widest operand the identity helper can describe.
    localparam int MAX_W = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [1:0] base_op(input logic [2:0] mode);
        case (mode)
            MODE_AND, MODE_NAND: return OP_AND;
            MODE_XOR, MODE_XNOR: return OP_XOR;
            default:             return OP_OR;
        endcase
    endfunction

    // Accumulator start value: all ones (within width) for AND-family, else zero.
    function automatic logic [MAX_W-1:0] identity(input logic [2:0] mode, input int width);
        logic [MAX_W-1:0] ones;
        ones = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        if (mode == MODE_AND || mode == MODE_NAND) begin
            return ones;
        end
        return '0;
    endfunction

    function automatic logic is_inverted(input logic [2:0] mode);
        return (mode == MODE_NAND) || (mode == MODE_NOR) || (mode == MODE_XNOR);
    endfunction

endpackage

// File: rtl/gate_reduce_alu.sv
// Combinational two-operand bitwise AND/OR/XOR selected by base op code.
module gate_reduce_alu
    import gate_reduce_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a | b;
        case (op)
            OP_AND:  y = a & b;
            OP_XOR:  y = a ^ b;
            default: y = a | b;
        endcase
    end

endmodule

// File: rtl/gate_reduce_seq.sv
// Streaming N_TERMS-operand bitwise reducer with selectable (inverted) op;
// one registered result per transaction, handed off over valid/ready.
module gate_reduce_seq
    import gate_reduce_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int N_TERMS = 3,
    parameter int CW      = $clog2(N_TERMS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic [CW-1:0]    count,
    output logic             mode_err
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] alu_y;
    logic [1:0]       op_q;
    logic             inv_q;
    logic [2:0]       mode_eff;
    logic             mode_rsvd;
    logic             beat;
    logic             last_beat;

    // Reserved codes fold onto OR so the transaction still completes.
    assign mode_rsvd = (mode > MODE_XNOR);
    assign mode_eff  = mode_rsvd ? MODE_OR : mode;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign beat      = in_valid && in_ready;
    assign last_beat = (count == CW'(N_TERMS - 1));

    gate_reduce_alu #(.WIDTH(WIDTH)) u_alu (
        .op (op_q),
        .a  (acc),
        .b  (in_data),
        .y  (alu_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = ACCUM;
            end
            ACCUM: begin
                if (flush)                  state_next = IDLE;
                else if (beat && last_beat) state_next = DONE;
            end
            DONE: begin
                if (flush || out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            out_data <= '0;
            count    <= '0;
            op_q     <= OP_OR;
            inv_q    <= 1'b0;
            mode_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= base_op(mode_eff);
                        inv_q <= is_inverted(mode_eff);
                        acc   <= WIDTH'(identity(mode_eff, WIDTH));
                        count <= '0;
                        if (mode_rsvd) mode_err <= 1'b1;
                    end
                end
                ACCUM: begin
                    // flush wins over a beat presented in the same cycle.
                    if (flush) begin
                        count <= '0;
                    end else if (beat) begin
                        acc   <= alu_y;
                        count <= count + CW'(1);
                        if (last_beat) out_data <= inv_q ? ~alu_y : alu_y;
                    end
                end
                DONE: begin
                    if (flush) count <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
